// File: rtl/pixel_cluster_st_source.sv
// Avalon-ST raster source: one frame per accepted start, pixels fg on a box outline and bg elsewhere.
// Optional macro PIXEL_CLUSTER_CTRL_PACKET_EN prepends a video control packet and a video header beat.
module pixel_cluster_st_source #(
  parameter int N_COLORS   = 3,
  parameter int COLOR_BITS = 8,
  parameter int X_MAX      = 640,
  parameter int Y_MAX      = 480,
  parameter int X_Y_BITS   = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [X_Y_BITS-1:0]            box_x,
  input  logic [X_Y_BITS-1:0]            box_y,
  input  logic [X_Y_BITS-1:0]            box_range,
  input  logic [N_COLORS*COLOR_BITS-1:0] fg_color,
  input  logic [N_COLORS*COLOR_BITS-1:0] bg_color,
  input  logic                           st_ready,
  output logic                           st_valid,
  output logic [N_COLORS*COLOR_BITS-1:0] st_data,
  output logic                           st_startofpacket,
  output logic                           st_endofpacket,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int DW = N_COLORS * COLOR_BITS;
  localparam logic [X_Y_BITS-1:0] XLAST = X_Y_BITS'(X_MAX - 1);
  localparam logic [X_Y_BITS-1:0] YLAST = X_Y_BITS'(Y_MAX - 1);
  localparam bit ONE_PIX = (X_MAX == 1) && (Y_MAX == 1);

`ifdef PIXEL_CLUSTER_CTRL_PACKET_EN
  typedef enum logic [2:0] {IDLE, CTRL, VHDR, STREAM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
`endif

  state_t                state_q;
  logic [X_Y_BITS-1:0]   x_q, y_q, x_d, y_d;
  logic [X_Y_BITS-1:0]   box_x_q, box_y_q, box_range_q;
  logic [DW-1:0]         fg_q, bg_q;
  logic                  st_valid_q, sop_q, eop_q, busy_q, frame_done_q;
  logic [DW-1:0]         st_data_q;
  logic                  pix_last;
  logic [DW-1:0]         nxt_data, first_data;
`ifdef PIXEL_CLUSTER_CTRL_PACKET_EN
  logic [1:0]            ctrl_cnt_q;
  logic [DW-1:0]         first_lat_data;
`endif

  // Distances are taken one bit wider and signed so boxes hanging off the frame clip instead of wrapping.
  function automatic logic on_outline(input logic [X_Y_BITS-1:0] px, input logic [X_Y_BITS-1:0] py,
                                      input logic [X_Y_BITS-1:0] bx, input logic [X_Y_BITS-1:0] by,
                                      input logic [X_Y_BITS-1:0] br);
    logic signed [X_Y_BITS:0] dx, dy;
    logic [X_Y_BITS:0] ax, ay, r;
    dx = $signed({1'b0, px}) - $signed({1'b0, bx});
    dy = $signed({1'b0, py}) - $signed({1'b0, by});
    ax = dx[X_Y_BITS] ? $unsigned(-dx) : $unsigned(dx);
    ay = dy[X_Y_BITS] ? $unsigned(-dy) : $unsigned(dy);
    r  = {1'b0, br};
    return ((ax == r) && (ay <= r)) || ((ay == r) && (ax <= r));
  endfunction

`ifdef PIXEL_CLUSTER_CTRL_PACKET_EN
  // Beat 0 is the 0xF type nibble; later beats carry width, height, interlace nibbles, first symbol in the MSBs.
  function automatic logic [DW-1:0] ctrl_beat(input logic [1:0] k);
    logic [15:0] w, h;
    logic [3:0]  n;
    int          idx;
    w = 16'(X_MAX);
    h = 16'(Y_MAX);
    ctrl_beat = '0;
    if (k == 2'd0) begin
      ctrl_beat[3:0] = 4'hF;
    end else begin
      for (int s = 0; s < N_COLORS; s++) begin
        idx = (int'(k) - 1) * N_COLORS + s;
        if (idx < 4)       n = w[4*(3-idx) +: 4];
        else if (idx < 8)  n = h[4*(7-idx) +: 4];
        else if (idx == 8) n = 4'h3;
        else               n = 4'h0;
        ctrl_beat[(N_COLORS-1-s)*COLOR_BITS +: 4] = n;
      end
    end
  endfunction
`endif

  always_comb begin
    x_d = x_q + 1'b1;
    y_d = y_q;
    if (x_q == XLAST) begin
      x_d = '0;
      y_d = y_q + 1'b1;
    end
    pix_last   = (x_q == XLAST) && (y_q == YLAST);
    nxt_data   = on_outline(x_d, y_d, box_x_q, box_y_q, box_range_q) ? fg_q : bg_q;
    first_data = on_outline('0, '0, box_x, box_y, box_range) ? fg_color : bg_color;
`ifdef PIXEL_CLUSTER_CTRL_PACKET_EN
    first_lat_data = on_outline('0, '0, box_x_q, box_y_q, box_range_q) ? fg_q : bg_q;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      box_x_q      <= '0;
      box_y_q      <= '0;
      box_range_q  <= '0;
      fg_q         <= '0;
      bg_q         <= '0;
      st_valid_q   <= 1'b0;
      st_data_q    <= '0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef PIXEL_CLUSTER_CTRL_PACKET_EN
      ctrl_cnt_q   <= '0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            box_x_q     <= box_x;
            box_y_q     <= box_y;
            box_range_q <= box_range;
            fg_q        <= fg_color;
            bg_q        <= bg_color;
            x_q         <= '0;
            y_q         <= '0;
            st_valid_q  <= 1'b1;
            busy_q      <= 1'b1;
            sop_q       <= 1'b1;
`ifdef PIXEL_CLUSTER_CTRL_PACKET_EN
            state_q     <= CTRL;
            ctrl_cnt_q  <= '0;
            st_data_q   <= ctrl_beat(2'd0);
            eop_q       <= 1'b0;
`else
            state_q     <= STREAM;
            st_data_q   <= first_data;
            eop_q       <= ONE_PIX;
`endif
          end
        end
`ifdef PIXEL_CLUSTER_CTRL_PACKET_EN
        CTRL: begin
          if (st_ready) begin
            if (ctrl_cnt_q == 2'd3) begin
              state_q   <= VHDR;
              st_data_q <= '0;
              sop_q     <= 1'b1;
              eop_q     <= 1'b0;
            end else begin
              ctrl_cnt_q <= ctrl_cnt_q + 2'd1;
              st_data_q  <= ctrl_beat(ctrl_cnt_q + 2'd1);
              sop_q      <= 1'b0;
              eop_q      <= (ctrl_cnt_q == 2'd2);
            end
          end
        end
        VHDR: begin
          if (st_ready) begin
            state_q   <= STREAM;
            st_data_q <= first_lat_data;
            sop_q     <= 1'b0;
            eop_q     <= ONE_PIX;
          end
        end
`endif
        STREAM: begin
          if (st_ready) begin
            if (pix_last) begin
              state_q      <= DONE;
              x_q          <= '0;
              y_q          <= '0;
              st_valid_q   <= 1'b0;
              st_data_q    <= '0;
              sop_q        <= 1'b0;
              eop_q        <= 1'b0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              x_q       <= x_d;
              y_q       <= y_d;
              st_data_q <= nxt_data;
              sop_q     <= 1'b0;
              eop_q     <= (x_d == XLAST) && (y_d == YLAST);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign st_valid         = st_valid_q;
  assign st_data          = st_data_q;
  assign st_startofpacket = sop_q;
  assign st_endofpacket   = eop_q;
  assign busy             = busy_q;
  assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_pixel_cluster_st_source.sv
// Bench for pixel_cluster_st_source on a 32x24 frame against a coordinate-level reference model.
module tb_pixel_cluster_st_source;
  localparam int XM = 32, YM = 24, NPIX = XM * YM;

  logic        clk = 1'b0;
  logic        reset_n, start, st_ready;
  logic [15:0] box_x, box_y, box_range;
  logic [23:0] fg_color, bg_color, st_data;
  logic        st_valid, sop, eop, busy, frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {logic [23:0] d; bit s; bit e;} beat_t;
  beat_t       exp_q[$];
  logic [23:0] pix_cap[NPIX];

  always #5 clk = ~clk;

  pixel_cluster_st_source #(.N_COLORS(3), .COLOR_BITS(8), .X_MAX(XM), .Y_MAX(YM), .X_Y_BITS(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .box_x(box_x), .box_y(box_y), .box_range(box_range),
    .fg_color(fg_color), .bg_color(bg_color), .st_ready(st_ready),
    .st_valid(st_valid), .st_data(st_data), .st_startofpacket(sop), .st_endofpacket(eop),
    .busy(busy), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_pix(int x, int y, int bx, int by, int br, logic [23:0] fg, logic [23:0] bg);
    int ax, ay;
    ax = (x > bx) ? x - bx : bx - x;
    ay = (y > by) ? y - by : by - y;
    return ((ax == br && ay <= br) || (ay == br && ax <= br)) ? fg : bg;
  endfunction

  task automatic build_exp(input int bx, input int by, input int br, input logic [23:0] fg, input logic [23:0] bg);
    beat_t b;
    exp_q.delete();
`ifdef PIXEL_CLUSTER_CTRL_PACKET_EN
    b = '{24'h00000F, 1'b1, 1'b0}; exp_q.push_back(b);
    b = '{24'h000002, 1'b0, 1'b0}; exp_q.push_back(b);
    b = '{24'h000000, 1'b0, 1'b0}; exp_q.push_back(b);
    b = '{24'h010803, 1'b0, 1'b1}; exp_q.push_back(b);
    b = '{24'h000000, 1'b1, 1'b0}; exp_q.push_back(b);
`endif
    for (int k = 0; k < NPIX; k++) begin
      b.d = ref_pix(k % XM, k / XM, bx, by, br, fg, bg);
`ifdef PIXEL_CLUSTER_CTRL_PACKET_EN
      b.s = 1'b0;
`else
      b.s = (k == 0);
`endif
      b.e = (k == NPIX - 1);
      exp_q.push_back(b);
    end
  endtask

  // Drives one frame; stall randomises st_ready, restart_at pulses a spurious start, reset_at aborts.
  task automatic run_frame(input int bx, input int by, input int br, input logic [23:0] fg, input logic [23:0] bg,
                           input bit stall, input int restart_at, input int reset_at);
    int n = 0, cyc = 0, npre;
    logic [23:0] pd;
    logic ps = 1'b0, pe = 1'b0;
    bit pstall = 0;
    build_exp(bx, by, br, fg, bg);
    npre = exp_q.size() - NPIX;
    @(negedge clk);
    start = 1'b1; box_x = 16'(bx); box_y = 16'(by); box_range = 16'(br); fg_color = fg; bg_color = bg;
    st_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    box_x = 16'($urandom); box_y = 16'($urandom); box_range = 16'($urandom_range(0, 5));
    fg_color = 24'($urandom); bg_color = 24'($urandom);
    chk("first_valid", st_valid, 1);
    pd = st_data;
    while (n < exp_q.size() && cyc < 20000) begin
      chk($sformatf("valid_b%0d", n), st_valid, 1);
      chk($sformatf("busy_b%0d", n), busy, 1);
      if (pstall) begin
        chk($sformatf("hold_data_b%0d", n), st_data, pd);
        chk($sformatf("hold_sop_b%0d", n), sop, ps);
        chk($sformatf("hold_eop_b%0d", n), eop, pe);
      end
      if (reset_at == n) begin
        reset_n = 1'b0;
        #1;
        chk("rst_valid", st_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_eop", eop, 0);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (restart_at == n) begin
        start = 1'b1; box_x = 16'(bx + 7); box_range = 16'(br + 1);
      end else begin
        start = 1'b0;
      end
      st_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (st_ready) begin
        chk($sformatf("data_b%0d", n), st_data, exp_q[n].d);
        chk($sformatf("sop_b%0d", n), sop, exp_q[n].s);
        chk($sformatf("eop_b%0d", n), eop, exp_q[n].e);
        if (n >= npre) pix_cap[n - npre] = st_data;
        n++;
        pstall = 0;
      end else begin
        pstall = 1; pd = st_data; ps = sop; pe = eop;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (n < exp_q.size()) chk("frame_timeout", 64'(n), 64'(exp_q.size()));
    chk("done_pulse", frame_done, 1);
    chk("valid_after_eop", st_valid, 0);
    @(negedge clk);
    chk("done_one_cycle", frame_done, 0);
    chk("busy_idle", busy, 0);
    chk("valid_idle", st_valid, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; st_ready = 1'b0;
    box_x = '0; box_y = '0; box_range = '0; fg_color = '0; bg_color = '0;
    repeat (2) @(negedge clk);
    chk("reset_valid", st_valid, 0);
    chk("reset_data", st_data, 0);
    chk("reset_sop", sop, 0);
    chk("reset_eop", eop, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", frame_done, 0);
    reset_n = 1'b1;

    run_frame(10, 10, 2, 24'hFF0000, 24'h000000, 0, -1, -1);
    for (int x = 8; x <= 12; x++) chk($sformatf("top_edge_x%0d", x), pix_cap[8*XM + x], 24'hFF0000);
    chk("corner_8_12", pix_cap[12*XM + 8], 24'hFF0000);
    chk("centre_10_10", pix_cap[10*XM + 10], 24'h000000);
    chk("inside_9_9", pix_cap[9*XM + 9], 24'h000000);

    run_frame(10, 10, 2, 24'hFF0000, 24'h000000, 1, -1, -1);
    run_frame(10, 10, 2, 24'hFF0000, 24'h000000, 0, 300, -1);
    run_frame(10, 10, 2, 24'hFF0000, 24'h000000, 0, -1, 100);
    run_frame(10, 10, 2, 24'hFF0000, 24'h000000, 0, -1, -1);

    run_frame(5, 7, 0, 24'h00FF00, 24'h123456, 0, -1, -1);
    chk("range0_centre", pix_cap[7*XM + 5], 24'h00FF00);
    chk("range0_neighbour", pix_cap[7*XM + 6], 24'h123456);

    run_frame(0, 0, 3, 24'h0000FF, 24'h101010, 1, -1, -1);
    run_frame(31, 23, 4, 24'hABCDEF, 24'h000001, 0, -1, -1);
    for (int r = 0; r < 3; r++)
      run_frame($urandom_range(0, 40), $urandom_range(0, 30), $urandom_range(0, 8),
                24'($urandom), 24'($urandom), 1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
